// File: rtl/lcd_byte_sequencer.sv
// Runs the HD44780 4-bit power-up sequence, then splits host bytes into high/low nibble
// transfers on the sendCommand/commandDone handshake; the low nibble polls the busy flag.
module lcd_byte_sequencer #(
  parameter int FREQ          = 50000000,
  parameter int POWERUP_US    = 15000,
  parameter int INIT_LONG_US  = 4100,
  parameter int INIT_SHORT_US = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  output logic       init_done,
  output logic       sendCommand,
  output logic [3:0] command,
  output logic       command_rs,
  output logic       read_busy,
  output logic       mode4bit,
  input  logic       commandDone
);

  localparam int CYC_US = FREQ / 1000000;
  localparam int TW     = $clog2(CYC_US * POWERUP_US + 1);

  localparam logic [TW-1:0] PWR_END   = TW'(CYC_US * POWERUP_US - 1);
  localparam logic [TW-1:0] LONG_END  = TW'(CYC_US * INIT_LONG_US - 1);
  localparam logic [TW-1:0] SHORT_END = TW'(CYC_US * INIT_SHORT_US - 1);

  localparam logic [3:0] S_PWR_WAIT    = 4'd0;
  localparam logic [3:0] S_INIT_SEND   = 4'd1;
  localparam logic [3:0] S_INIT_DONE_W = 4'd2;
  localparam logic [3:0] S_INIT_WAIT   = 4'd3;
  localparam logic [3:0] S_CFG         = 4'd4;
  localparam logic [3:0] S_IDLE        = 4'd5;
  localparam logic [3:0] S_SEND_HI     = 4'd6;
  localparam logic [3:0] S_WAIT_HI     = 4'd7;
  localparam logic [3:0] S_GAP         = 4'd8;
  localparam logic [3:0] S_SEND_LO     = 4'd9;
  localparam logic [3:0] S_WAIT_LO     = 4'd10;
  localparam logic [3:0] S_GAP2        = 4'd11;

  logic [3:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_idx;
  logic [3:0]    r_lo_nib;
  logic          r_init_done;
  logic          r_send;
  logic [3:0]    r_cmd;
  logic          r_cmd_rs;
  logic          r_read_busy;
  logic          r_mode4;

  logic [7:0]    w_cfg_byte;
  logic          w_init_wait_end;
  logic          w_wr_ready;

  // Function set 4-bit/2-line, display on, clear, entry mode increment.
  always_comb begin
    w_cfg_byte = 8'h06;
    case (r_idx)
      2'd0:    w_cfg_byte = 8'h28;
      2'd1:    w_cfg_byte = 8'h0C;
      2'd2:    w_cfg_byte = 8'h01;
      default: w_cfg_byte = 8'h06;
    endcase
  end

  assign w_init_wait_end = (r_timer == ((r_idx == 2'd0) ? LONG_END : SHORT_END));
  assign w_wr_ready      = (r_state == S_IDLE) && r_init_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_PWR_WAIT;
      r_timer     <= '0;
      r_idx       <= '0;
      r_lo_nib    <= '0;
      r_init_done <= 1'b0;
      r_send      <= 1'b0;
      r_cmd       <= '0;
      r_cmd_rs    <= 1'b0;
      r_read_busy <= 1'b0;
      r_mode4     <= 1'b0;
    end else begin
      r_timer <= r_timer + 1'b1;
      r_send  <= 1'b0;
      case (r_state)
        S_PWR_WAIT: if (r_timer == PWR_END) begin
          r_state     <= S_INIT_SEND;
          r_timer     <= '0;
          r_send      <= 1'b1;
          r_cmd       <= 4'h3;
          r_cmd_rs    <= 1'b0;
          r_read_busy <= 1'b0;
          r_mode4     <= 1'b0;
        end
        S_INIT_SEND: begin
          r_state <= S_INIT_DONE_W;
          r_timer <= '0;
        end
        S_INIT_DONE_W: if (commandDone) begin
          r_state <= S_INIT_WAIT;
          r_timer <= '0;
        end
        S_INIT_WAIT: if (w_init_wait_end) begin
          r_timer <= '0;
          if (r_idx == 2'd3) begin
            r_state <= S_CFG;
            r_idx   <= '0;
          end else begin
            r_state <= S_INIT_SEND;
            r_idx   <= r_idx + 1'b1;
            r_send  <= 1'b1;
            r_cmd   <= (r_idx == 2'd2) ? 4'h2 : 4'h3;
          end
        end
        S_CFG: begin
          r_state     <= S_SEND_HI;
          r_timer     <= '0;
          r_lo_nib    <= w_cfg_byte[3:0];
          r_send      <= 1'b1;
          r_cmd       <= w_cfg_byte[7:4];
          r_cmd_rs    <= 1'b0;
          r_read_busy <= 1'b0;
          r_mode4     <= 1'b1;
        end
        S_IDLE: if (wr_valid && w_wr_ready) begin
          r_state     <= S_SEND_HI;
          r_timer     <= '0;
          r_lo_nib    <= wr_data[3:0];
          r_send      <= 1'b1;
          r_cmd       <= wr_data[7:4];
          r_cmd_rs    <= wr_rs;
          r_read_busy <= 1'b0;
          r_mode4     <= 1'b1;
        end
        S_SEND_HI: begin
          r_state <= S_WAIT_HI;
          r_timer <= '0;
        end
        S_WAIT_HI: if (commandDone) begin
          r_state <= S_GAP;
          r_timer <= '0;
        end
        // The transfer stage sits one cycle in done_tick; GAP covers it. command_rs is kept.
        S_GAP: begin
          r_state     <= S_SEND_LO;
          r_timer     <= '0;
          r_send      <= 1'b1;
          r_cmd       <= r_lo_nib;
          r_read_busy <= 1'b1;
          r_mode4     <= 1'b1;
        end
        S_SEND_LO: begin
          r_state <= S_WAIT_LO;
          r_timer <= '0;
        end
        S_WAIT_LO: if (commandDone) begin
          r_state <= S_GAP2;
          r_timer <= '0;
          if (!r_init_done) begin
            if (r_idx == 2'd3) r_init_done <= 1'b1;
            else               r_idx       <= r_idx + 1'b1;
          end
        end
        S_GAP2: begin
          r_state <= r_init_done ? S_IDLE : S_CFG;
          r_timer <= '0;
        end
        default: begin
          r_state <= S_PWR_WAIT;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign wr_ready    = w_wr_ready;
  assign init_done   = r_init_done;
  assign sendCommand = r_send;
  assign command     = r_cmd;
  assign command_rs  = r_cmd_rs;
  assign read_busy   = r_read_busy;
  assign mode4bit    = r_mode4;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Bench for lcd_byte_sequencer: a transfer-stage model answers each sendCommand with a
// commandDone 20 cycles later; logged nibbles are compared against hand-written tables.
`timescale 1ns/1ps
module tb_lcd_byte_sequencer;
  // Scaled timing: 2 cycles per us keeps the full power-up well inside the cycle budget.
  localparam int FREQ     = 2000000;
  localparam int PWR_US   = 1000;
  localparam int LONG_US  = 41;
  localparam int SHORT_US = 10;
  localparam int PWR_N    = 2000;
  localparam int LONG_N   = 82;
  localparam int SHORT_N  = 20;
  localparam int DLY      = 20;
  localparam int MAXC     = 40000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       wr_rs = 1'b0;
  logic       init_done;
  logic       sendCommand;
  logic [3:0] command;
  logic       command_rs;
  logic       read_busy;
  logic       mode4bit;
  logic       commandDone = 1'b0;

  lcd_byte_sequencer #(
    .FREQ(FREQ), .POWERUP_US(PWR_US), .INIT_LONG_US(LONG_US), .INIT_SHORT_US(SHORT_US)
  ) dut (
    .CLK(CLK), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_rs(wr_rs), .init_done(init_done), .sendCommand(sendCommand), .command(command),
    .command_rs(command_rs), .read_busy(read_busy), .mode4bit(mode4bit),
    .commandDone(commandDone)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [3:0] nib; logic rs; logic rb; logic m4; } nib_vec_t;
  typedef struct { logic [7:0] data; logic rs; logic [3:0] hi; logic [3:0] lo; } host_vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor/model state, owned by the negedge process below.
  int         cyc = 0;
  int         s_cyc[$];
  logic [3:0] s_nib[$];
  logic       s_rs[$], s_rb[$], s_m4[$];
  int         d_cyc[$];
  int         acc_cyc[$];
  logic       ready_tr[MAXC];
  int         init_rise = -1;
  int         acc_at_init = -1;
  int         nib_at_init = -1;
  int         stray_cnt = 0;
  int         epoch = 0;
  int         seen_epoch = 0;
  int         cnt = 0;
  int         last_done = -1000;
  logic [6:0] pend_val = '0;
  int         pend_epoch = 0;

  function automatic logic rdy(input int c);
    if (c < 0 || c >= MAXC) return 1'b0;
    return ready_tr[c];
  endfunction

  // cycle k runs from posedge k to posedge k+1; everything is sampled at negedge k.
  initial begin
    forever begin
      @(negedge CLK);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        s_cyc.delete(); s_nib.delete(); s_rs.delete(); s_rb.delete(); s_m4.delete();
        d_cyc.delete(); acc_cyc.delete();
        init_rise = -1; acc_at_init = -1; nib_at_init = -1; stray_cnt = 0;
      end
      if (cyc < MAXC) ready_tr[cyc] = wr_ready;
      if (wr_valid && wr_ready) acc_cyc.push_back(cyc);
      if (init_done && init_rise < 0) begin
        init_rise   = cyc;
        acc_at_init = acc_cyc.size();
        nib_at_init = s_cyc.size();
      end
      commandDone = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          commandDone = 1'b1;
          d_cyc.push_back(cyc);
          last_done = cyc;
          if (pend_epoch == seen_epoch)
            check("held_until_done", {command, command_rs, read_busy, mode4bit}, pend_val);
          else
            stray_cnt++;
        end
      end
      if (sendCommand) begin
        check("send_while_busy", cnt, 0);
        check("send_gap_ge2", (cyc - last_done) >= 2, 1);
        s_cyc.push_back(cyc); s_nib.push_back(command); s_rs.push_back(command_rs);
        s_rb.push_back(read_busy); s_m4.push_back(mode4bit);
        cnt        = DLY;
        pend_val   = {command, command_rs, read_busy, mode4bit};
        pend_epoch = seen_epoch;
      end
      cyc++;
    end
  end

  // kind 0: sends, 1: accepts, 2: dones, 3: init_done seen.
  task automatic wait_for(input int kind, input int n, input int budget, input string name);
    int i = 0;
    int have = 0;
    while (i < budget) begin
      case (kind)
        0: have = s_cyc.size();
        1: have = acc_cyc.size();
        2: have = d_cyc.size();
        default: have = (init_rise >= 0) ? 1 : 0;
      endcase
      if (have >= n) break;
      @(posedge CLK);
      i++;
    end
    #1;
    check(name, have >= n, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sendCommand"}, sendCommand, 0);
    check({tag, "_command"}, command, 0);
    check({tag, "_command_rs"}, command_rs, 0);
    check({tag, "_read_busy"}, read_busy, 0);
    check({tag, "_mode4bit"}, mode4bit, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_wr_ready"}, wr_ready, 0);
  endtask

  task automatic check_init_table(input string tag, input nib_vec_t iv[12]);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_nib%0d", tag, i), {s_nib[i], s_rs[i], s_rb[i], s_m4[i]},
            {iv[i].nib, iv[i].rs, iv[i].rb, iv[i].m4});
  endtask

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
    $fatal(1, "watchdog");
  end

  initial begin
    nib_vec_t  iv[12];
    host_vec_t hv[3];
    int        rel;
    int        zeros;

    iv[0]  = '{4'h3, 1'b0, 1'b0, 1'b0}; iv[1]  = '{4'h3, 1'b0, 1'b0, 1'b0};
    iv[2]  = '{4'h3, 1'b0, 1'b0, 1'b0}; iv[3]  = '{4'h2, 1'b0, 1'b0, 1'b0};
    iv[4]  = '{4'h2, 1'b0, 1'b0, 1'b1}; iv[5]  = '{4'h8, 1'b0, 1'b1, 1'b1};
    iv[6]  = '{4'h0, 1'b0, 1'b0, 1'b1}; iv[7]  = '{4'hC, 1'b0, 1'b1, 1'b1};
    iv[8]  = '{4'h0, 1'b0, 1'b0, 1'b1}; iv[9]  = '{4'h1, 1'b0, 1'b1, 1'b1};
    iv[10] = '{4'h0, 1'b0, 1'b0, 1'b1}; iv[11] = '{4'h6, 1'b0, 1'b1, 1'b1};
    hv[0]  = '{8'h41, 1'b1, 4'h4, 4'h1};
    hv[1]  = '{8'h48, 1'b0, 4'h4, 4'h8};
    hv[2]  = '{8'h49, 1'b0, 4'h4, 4'h9};

    // wr_valid held high through reset and power-up: nothing may be accepted early.
    wr_valid = 1'b1; wr_data = hv[0].data; wr_rs = hv[0].rs;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");

    @(posedge CLK); #1;
    RST = 1'b0;
    rel = cyc;

    wait_for(1, 1, 4000, "first_accept_timeout");
    wr_valid = 1'b0;
    check("first_send_latency", s_cyc[0] - rel, PWR_N);
    check("accepts_before_init", acc_at_init, 0);
    check("nibbles_before_init", nib_at_init, 12);
    check_init_table("init", iv);
    check("gap_long", s_cyc[1] - s_cyc[0], DLY + LONG_N + 1);
    check("gap_short1", s_cyc[2] - s_cyc[1], DLY + SHORT_N + 1);
    check("gap_short2", s_cyc[3] - s_cyc[2], DLY + SHORT_N + 1);
    check("gap_to_cfg", s_cyc[4] - s_cyc[3], DLY + SHORT_N + 2);
    check("init_done_rise", init_rise, d_cyc[11] + 1);
    check("ready_low_at_rise", rdy(init_rise), 0);
    check("ready_after_rise", rdy(init_rise + 1), 1);
    check("accept_at_first_ready", acc_cyc[0], init_rise + 1);

    wait_for(2, 14, 200, "byte0_done_timeout");
    repeat (4) @(posedge CLK); #1;

    // Back-to-back bytes with wr_valid held; data switches right after the first accept.
    wr_valid = 1'b1; wr_data = hv[1].data; wr_rs = hv[1].rs;
    wait_for(1, 2, 200, "byte1_accept_timeout");
    wr_data = hv[2].data; wr_rs = hv[2].rs;
    wait_for(1, 3, 200, "byte2_accept_timeout");
    wr_valid = 1'b0;
    wait_for(2, 18, 200, "byte2_done_timeout");
    repeat (6) @(posedge CLK); #1;
    check("accept_count", acc_cyc.size(), 3);

    for (int j = 0; j < 3; j++) begin
      check($sformatf("byte%0d_hi", j), {s_nib[12+2*j], s_rs[12+2*j], s_rb[12+2*j], s_m4[12+2*j]},
            {hv[j].hi, hv[j].rs, 1'b0, 1'b1});
      check($sformatf("byte%0d_lo", j), {s_nib[13+2*j], s_rs[13+2*j], s_rb[13+2*j], s_m4[13+2*j]},
            {hv[j].lo, hv[j].rs, 1'b1, 1'b1});
      check($sformatf("byte%0d_hi_latency", j), s_cyc[12+2*j] - acc_cyc[j], 1);
      check($sformatf("byte%0d_lo_spacing", j), s_cyc[13+2*j] - d_cyc[12+2*j], 2);
      check($sformatf("byte%0d_ready_back", j), rdy(d_cyc[13+2*j] + 2), 1);
      zeros = 0;
      for (int c = acc_cyc[j] + 1; c <= d_cyc[13+2*j] + 1; c++) zeros += int'(rdy(c));
      check($sformatf("byte%0d_ready_low_span", j), zeros, 0);
    end
    check("b2b_accept", acc_cyc[2], d_cyc[15] + 2);

    // Reset between the high and low nibble of a fresh byte.
    wr_valid = 1'b1; wr_data = 8'h5A; wr_rs = 1'b1;
    wait_for(0, 19, 200, "byte3_hi_timeout");
    wr_valid = 1'b0;
    repeat (5) @(posedge CLK); #1;
    RST = 1'b1;
    epoch++;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge CLK); #1;
    RST = 1'b0;
    rel = cyc;
    wait_for(3, 1, 4000, "replay_init_timeout");
    check("stray_done_seen", stray_cnt, 1);
    check("replay_first_send", s_cyc[0] - rel, PWR_N);
    check("replay_nibbles", nib_at_init, 12);
    check_init_table("replay", iv);
    repeat (3) @(posedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
